// File: rtl/lamp_state_pkg.sv
// ============================================================================
// Module      : lamp_state_pkg
// Description : Shared constants and types for the lamp-bank driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lamp_state_pkg;

    localparam int c_n_lamps = 16;
    localparam int c_sel_w   = 4;

    typedef logic [c_n_lamps-1:0] lamp_vec_t;

endpackage

`default_nettype wire

// File: rtl/lamp_state_therm_decode.sv
// ============================================================================
// Module      : therm_decode
// Description : Combinational count-to-thermometer decoder with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module therm_decode
    import lamp_state_pkg::*;
#(
    parameter int N_LAMPS = c_n_lamps,
    parameter int SEL_W   = c_sel_w
) (
    input  logic [SEL_W-1:0]   count,
    output logic [N_LAMPS-1:0] therm
);

    // Counts at or above N_LAMPS light every bit, so saturation falls out of
    // the per-bit compare without a separate clamp.
    logic [31:0] w_count;
    assign w_count = 32'(count);

    for (genvar i = 0; i < N_LAMPS; i++) begin : g_bit
        localparam logic [31:0] c_idx = 32'(i);
        assign therm[i] = (w_count > c_idx);
    end

endmodule

`default_nettype wire

// File: rtl/lamp_state.sv
// ============================================================================
// Module      : lamp_state
// Description : Registered thermometer lamp driver with all-off/all-on flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lamp_state
    import lamp_state_pkg::*;
#(
    parameter int N_LAMPS = c_n_lamps,
    parameter int SEL_W   = c_sel_w
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   active_lights,
    output logic [N_LAMPS-1:0] lights_state,
    output logic               all_off,
    output logic               all_on
);

    logic [N_LAMPS-1:0] w_next;
    logic [N_LAMPS-1:0] r_lights;
    logic               r_all_off;
    logic               r_all_on;

    therm_decode #(
        .N_LAMPS (N_LAMPS),
        .SEL_W   (SEL_W)
    ) u_therm_decode (
        .count (active_lights),
        .therm (w_next)
    );

    // Flags derive from the decoded value so they register in step with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lights  <= '0;
            r_all_off <= 1'b1;
            r_all_on  <= 1'b0;
        end else begin
            r_lights  <= w_next;
            r_all_off <= (w_next == '0);
            r_all_on  <= (w_next == '1);
        end
    end

    assign lights_state = r_lights;
    assign all_off      = r_all_off;
    assign all_on       = r_all_on;

endmodule

`default_nettype wire

// File: tb/tb_lamp_state.sv
// ============================================================================
// Module      : tb_lamp_state
// Description : Randomized self-checking bench for lamp_state (16 and 8 lamps).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lamp_state;
    import lamp_state_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  al  = 4'd0;
    logic [3:0]  al8 = 4'd0;
    lamp_vec_t   ls;
    logic        off16, on16;
    logic [7:0]  ls8;
    logic        off8, on8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lamp_state dut (
        .clk           (clk),
        .rst           (rst),
        .active_lights (al),
        .lights_state  (ls),
        .all_off       (off16),
        .all_on        (on16)
    );

    lamp_state #(.N_LAMPS(8), .SEL_W(4)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .active_lights (al8),
        .lights_state  (ls8),
        .all_off       (off8),
        .all_on        (on8)
    );

    // Reference: k lamps lit from bit 0, clipped at n lamps.
    function automatic logic [15:0] lit(input int k, input int n);
        int m;
        m = (k > n) ? n : k;
        return 16'((32'd1 << m) - 1);
    endfunction

    function automatic logic [17:0] exp16(input int k);
        logic [15:0] v;
        v = lit(k, 16);
        return {v, v == 16'h0000, v == 16'hFFFF};
    endfunction

    function automatic logic [9:0] exp8(input int k);
        logic [7:0] v;
        v = 8'(lit(k, 8));
        return {v, v == 8'h00, v == 8'hFF};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        al  = 4'b1010;
        al8 = 4'b1010;
        for (int c = 0; c < 2; c++) begin
            tick();
            total_cnt++;
            if ({ls, off16, on16} !== {16'h0000, 1'b1, 1'b0})
                $display("FAIL reset16 cyc%0d: got %h/%b/%b want 0000/1/0", c, ls, off16, on16);
            else pass_cnt++;
            total_cnt++;
            if ({ls8, off8, on8} !== {8'h00, 1'b1, 1'b0})
                $display("FAIL reset8 cyc%0d: got %h/%b/%b want 00/1/0", c, ls8, off8, on8);
            else pass_cnt++;
        end
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({ls, off16, on16} !== {16'h03FF, 1'b0, 1'b0})
            $display("FAIL reset_release: got %h/%b/%b want 03ff/0/0", ls, off16, on16);
        else pass_cnt++;
    endtask

    task automatic test_sweep;
        for (int k = 0; k < 16; k++) begin
            al = 4'(k);
            for (int c = 0; c < 10; c++) begin
                tick();
                total_cnt++;
                if ({ls, off16, on16} !== exp16(k))
                    $display("FAIL sweep k=%0d cyc%0d: got %h/%b/%b want %h", k, c, ls, off16, on16, exp16(k));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int seq [4] = '{3, 12, 0, 15};
        logic [15:0] want [4] = '{16'h0007, 16'h0FFF, 16'h0000, 16'h7FFF};
        for (int j = 0; j < 4; j++) begin
            al = 4'(seq[j]);
            tick();
            total_cnt++;
            if ({ls, off16, on16} !== {want[j], want[j] == 16'h0, 1'b0})
                $display("FAIL b2b step%0d: got %h/%b/%b want %h", j, ls, off16, on16, want[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset;
        al = 4'd9;
        tick();
        tick();
        total_cnt++;
        if (ls !== 16'h01FF) $display("FAIL midrst_pre: got %h want 01ff", ls);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({ls, off16, on16} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL midrst_edge: got %h/%b/%b want 0000/1/0", ls, off16, on16);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (ls !== 16'h01FF) $display("FAIL midrst_post: got %h want 01ff", ls);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        int ks [3] = '{8, 13, 7};
        logic [9:0] want [3] = '{{8'hFF, 1'b0, 1'b1}, {8'hFF, 1'b0, 1'b1}, {8'h7F, 1'b0, 1'b0}};
        for (int j = 0; j < 3; j++) begin
            al8 = 4'(ks[j]);
            tick();
            total_cnt++;
            if ({ls8, off8, on8} !== want[j])
                $display("FAIL sat k=%0d: got %h/%b/%b want %h", ks[j], ls8, off8, on8, want[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        int k16, k8;
        logic r;
        for (int c = 0; c < 300; c++) begin
            k16 = int'($urandom_range(15, 0));
            k8  = int'($urandom_range(15, 0));
            r   = ($urandom_range(15, 0) == 0);
            al  = 4'(k16);
            al8 = 4'(k8);
            rst = r;
            tick();
            total_cnt++;
            if ({ls, off16, on16} !== (r ? {16'h0000, 1'b1, 1'b0} : exp16(k16)))
                $display("FAIL rand16 cyc%0d k=%0d rst=%b: got %h/%b/%b", c, k16, r, ls, off16, on16);
            else pass_cnt++;
            total_cnt++;
            if ({ls8, off8, on8} !== (r ? {8'h00, 1'b1, 1'b0} : exp8(k8)))
                $display("FAIL rand8 cyc%0d k=%0d rst=%b: got %h/%b/%b", c, k8, r, ls8, off8, on8);
            else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
